wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 64, width of cycle and instret counters.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port regs_in  input  stage_regs  instruction leaving mem (pc, ctrl, alu, br, rd, valid).
REQ-005 SHALL have port dcache_out  input  32  registered load word from mem.
REQ-006 SHALL have port stall_in  input  1  high = pipeline frozen, regs_in held.
REQ-007 SHALL have port load_regfile  output  1  regfile write enable.
REQ-008 SHALL have port rd  output  5  regfile write index.
REQ-009 SHALL have port rd_data  output  32  regfile write data.
REQ-010 SHALL have port hazard_wb  output  1  bypass valid for the decode stage.
REQ-011 SHALL have port wb_fwd  output  32  bypass data.
REQ-012 SHALL have port fwd_rd  output  5  bypass register index.
REQ-013 SHALL have port load_misalign  output  1  one-cycle pulse on a misaligned retiring load.
REQ-014 SHALL have ports cycle_count, instret_count  output  CNT_W  performance counters.

Function
REQ-015 SHALL select rd_data by regs_in.ctrl.regfilemux_sel: alu -> regs_in.alu; br -> zero-extended regs_in.br; load -> aligned load; pc_plus4 -> regs_in.pc + 4, 32-bit wrap.
REQ-016 SHALL align loads by alu[1:0]: lb/lbu select byte alu[1:0]; lh/lhu select halfword alu[1]; lw full word; lb/lh sign-extend, lbu/lhu zero-extend.
REQ-017 SHALL flag misalignment: lh/lhu with alu[0]=1, lw with alu[1:0]!=0; load_regfile suppressed; load_misalign pulses once.
REQ-018 SHALL assert load_regfile = valid & ctrl.load_regfile & (rd!=0) & ~retired & ~misaligned.
REQ-019 SHALL retire an instruction exactly once: internal retired flag set at the edge where a valid instruction retires while stall_in=1, cleared at the first edge with stall_in=0.
REQ-020 SHALL increment instret_count by 1 at each retiring edge (valid & ~retired, misaligned loads included); no increment on bubbles or held repeats.
REQ-021 SHALL increment cycle_count every cycle, wrap from all-ones to 0; instret_count wraps likewise.
REQ-022 SHALL register the last regfile write: at an edge with load_regfile=1, fwd_rd<=rd, wb_fwd<=rd_data, hazard_wb<=1.
REQ-023 SHALL hold fwd_rd/wb_fwd/hazard_wb when no write occurs; a later write to another rd replaces them.
REQ-024 SHALL never assert hazard_wb for rd=0.
REQ-025 SHALL treat rd, rd_data as combinational from regs_in; load_regfile, load_misalign also combinational, zero when valid=0.

Reset
REQ-026 SHALL, while reset=0, clear retired, hazard_wb, fwd_rd, wb_fwd, cycle_count, instret_count to 0 asynchronously.
REQ-027 SHALL, on reset assertion mid-stall, discard retired state; the first instruction after release retires and counts normally.
REQ-028 SHALL resume counting cycle_count at the first rising edge after reset deasserts (value 1 after that edge).

Structure
REQ-029 SHALL take stage_regs, regfilemux_sel, load_type enumerations from rv32i_types; add misalign-check constants there.
REQ-030 SHALL place load alignment/extension in sub-module load_align (combinational, inputs load_type, alu[1:0], dcache_out).
REQ-031 SHALL reuse existing register module only where its reset polarity matches; counters and flags coded locally.

Verification
REQ-032 SHALL cover lb, alu[1:0]=3, dcache_out=0x80FF_1234 -> rd_data=0xFFFF_FF80, load_regfile=1.
REQ-033 SHALL cover lhu, alu[1:0]=2, dcache_out=0xBEEF_0000 -> rd_data=0x0000_BEEF; lh same -> 0xFFFF_BEEF.
REQ-034 SHALL cover a valid alu write rd=5, 0x1234 held with stall_in=1 for 3 cycles -> load_regfile high only the first cycle, instret_count +1, hazard_wb=1, fwd_rd=5, wb_fwd=0x1234.
REQ-035 SHALL cover lw with alu[1:0]=2 -> load_regfile=0, load_misalign single pulse, instret_count +1, bypass unchanged.
REQ-036 SHALL cover write to rd=0 with alu=0xFFFF_FFFF -> load_regfile=0, hazard_wb unchanged.
REQ-037 SHALL cover reset low mid-stall after 10 cycles -> all counters/bypass 0 immediately, no clock edge required.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared pipeline types for the RV32I core, plus the load-alignment rule used by writeback.
package rv32i_types;

    typedef enum logic [1:0] {
        RF_ALU,
        RF_BR,
        RF_LOAD,
        RF_PC_PLUS4
    } regfilemux_sel_t;

    typedef enum logic [2:0] {
        LD_LB,
        LD_LH,
        LD_LW,
        LD_LBU,
        LD_LHU
    } load_type_t;

    typedef struct packed {
        logic            load_regfile;
        regfilemux_sel_t regfilemux_sel;
        load_type_t      load_type;
    } ctrl_word_t;

    typedef struct packed {
        logic [31:0] pc;
        ctrl_word_t  ctrl;
        logic [31:0] alu;
        logic        br;
        logic [4:0]  rd;
        logic        valid;
    } stage_regs;

    // Offset bits that must be zero for an access of the given size.
    localparam logic [1:0] HALF_MISALIGN_MASK = 2'b01;
    localparam logic [1:0] WORD_MISALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input load_type_t t, input logic [1:0] off);
        case (t)
            LD_LH, LD_LHU: is_misaligned = |(off & HALF_MISALIGN_MASK);
            LD_LW:         is_misaligned = |(off & WORD_MISALIGN_MASK);
            default:       is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load data alignment and sign/zero extension for the writeback stage.
module load_align
    import rv32i_types::*;
(
    input  load_type_t  i_load_type,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_dcache_out,
    output logic [31:0] o_data,
    output logic        o_misaligned
);

    logic [31:0] w_byte_shift;
    logic [31:0] w_half_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte_shift = i_dcache_out >> {i_offset, 3'b000};
        w_half_shift = i_dcache_out >> {i_offset[1], 4'b0000};
        w_byte       = w_byte_shift[7:0];
        w_half       = w_half_shift[15:0];
        o_misaligned = is_misaligned(i_load_type, i_offset);
        case (i_load_type)
            LD_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  o_data = {24'h0, w_byte};
            LD_LH:   o_data = {{16{w_half[15]}}, w_half};
            LD_LHU:  o_data = {16'h0, w_half};
            default: o_data = i_dcache_out;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: regfile write selection, exactly-once retirement under stall,
// decode-stage bypass register and cycle/instret performance counters.
module wb_stage
    import rv32i_types::*;
#(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  stage_regs        regs_in,
    input  logic [31:0]      dcache_out,
    input  logic             stall_in,
    output logic             load_regfile,
    output logic [4:0]       rd,
    output logic [31:0]      rd_data,
    output logic             hazard_wb,
    output logic [31:0]      wb_fwd,
    output logic [4:0]       fwd_rd,
    output logic             load_misalign,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    logic             r_retired;
    logic             r_hazard_wb;
    logic [31:0]      r_wb_fwd;
    logic [4:0]       r_fwd_rd;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_instret_count;

    logic [31:0] w_load_data;
    logic        w_align_misaligned;
    logic        w_misaligned;
    logic        w_retiring;

    load_align u_load_align (
        .i_load_type  (regs_in.ctrl.load_type),
        .i_offset     (regs_in.alu[1:0]),
        .i_dcache_out (dcache_out),
        .o_data       (w_load_data),
        .o_misaligned (w_align_misaligned)
    );

    always_comb begin
        w_misaligned  = (regs_in.ctrl.regfilemux_sel == RF_LOAD) & w_align_misaligned;
        w_retiring    = regs_in.valid & ~r_retired;
        rd            = regs_in.rd;
        load_regfile  = w_retiring & regs_in.ctrl.load_regfile & (regs_in.rd != 5'd0) & ~w_misaligned;
        load_misalign = w_retiring & w_misaligned;
        case (regs_in.ctrl.regfilemux_sel)
            RF_ALU:      rd_data = regs_in.alu;
            RF_BR:       rd_data = {31'h0, regs_in.br};
            RF_LOAD:     rd_data = w_load_data;
            RF_PC_PLUS4: rd_data = regs_in.pc + 32'd4;
            default:     rd_data = regs_in.alu;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired       <= 1'b0;
            r_hazard_wb     <= 1'b0;
            r_wb_fwd        <= '0;
            r_fwd_rd        <= '0;
            r_cycle_count   <= '0;
            r_instret_count <= '0;
        end else begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (w_retiring) begin
                r_instret_count <= r_instret_count + CNT_W'(1);
            end
            // A held instruction stays marked retired until the pipeline advances.
            r_retired <= stall_in & (r_retired | regs_in.valid);
            if (load_regfile) begin
                r_hazard_wb <= 1'b1;
                r_fwd_rd    <= regs_in.rd;
                r_wb_fwd    <= rd_data;
            end
        end
    end

    assign hazard_wb     = r_hazard_wb;
    assign wb_fwd        = r_wb_fwd;
    assign fwd_rd        = r_fwd_rd;
    assign cycle_count   = r_cycle_count;
    assign instret_count = r_instret_count;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage with narrow counters so wraparound is reachable.
module tb_wb_stage;
    import rv32i_types::*;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    stage_regs     regs;
    logic [31:0]   dcache;
    logic          stall;
    logic          load_regfile;
    logic [4:0]    rd;
    logic [31:0]   rd_data;
    logic          hazard_wb;
    logic [31:0]   wb_fwd;
    logic [4:0]    fwd_rd;
    logic          load_misalign;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] instret_count;

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    logic [CW-1:0] exp_cyc;
    logic [CW-1:0] exp_ins;

    wb_stage #(.CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .regs_in       (regs),
        .dcache_out    (dcache),
        .stall_in      (stall),
        .load_regfile  (load_regfile),
        .rd            (rd),
        .rd_data       (rd_data),
        .hazard_wb     (hazard_wb),
        .wb_fwd        (wb_fwd),
        .fwd_rd        (fwd_rd),
        .load_misalign (load_misalign),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        exp_cyc = exp_cyc + 1'b1;
    endtask

    task automatic check_ctrs(input string tag);
        check({tag, "_cycle"}, 64'(cycle_count), 64'(exp_cyc));
        check({tag, "_instret"}, 64'(instret_count), 64'(exp_ins));
    endtask

    task automatic check_bypass(input string tag, input logic hz, input logic [4:0] r, input logic [31:0] d);
        check({tag, "_hazard"}, 64'(hazard_wb), 64'(hz));
        check({tag, "_fwd_rd"}, 64'(fwd_rd), 64'(r));
        check({tag, "_wb_fwd"}, 64'(wb_fwd), 64'(d));
    endtask

    task automatic drive(input logic v, input logic ldrf, input regfilemux_sel_t sel,
                         input load_type_t lt, input logic [4:0] r, input logic [31:0] alu,
                         input logic b, input logic [31:0] pc, input logic [31:0] dc);
        regs.valid               = v;
        regs.ctrl.load_regfile   = ldrf;
        regs.ctrl.regfilemux_sel = sel;
        regs.ctrl.load_type      = lt;
        regs.rd                  = r;
        regs.alu                 = alu;
        regs.br                  = b;
        regs.pc                  = pc;
        dcache                   = dc;
    endtask

    initial begin
        reset   = 1'b0;
        stall   = 1'b0;
        exp_cyc = '0;
        exp_ins = '0;
        drive(1'b0, 1'b0, RF_ALU, LD_LW, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        #2;
        check_ctrs("rst_early");
        check_bypass("rst_early", 1'b0, 5'd0, 32'h0);
        #20;
        check_ctrs("rst_held");
        reset = 1'b1;
        tick();
        check_ctrs("first_edge");

        // lb byte 3, sign extended
        drive(1'b1, 1'b1, RF_LOAD, LD_LB, 5'd7, 32'h0000_1003, 1'b0, 32'h100, 32'h80FF_1234);
        #1;
        check("lb_data", 64'(rd_data), 64'hFFFF_FF80);
        check("lb_ldrf", 64'(load_regfile), 64'd1);
        check("lb_rd", 64'(rd), 64'd7);
        check("lb_mis", 64'(load_misalign), 64'd0);
        tick(); exp_ins++;
        check_ctrs("lb");
        check_bypass("lb", 1'b1, 5'd7, 32'hFFFF_FF80);

        // lhu / lh upper halfword
        drive(1'b1, 1'b1, RF_LOAD, LD_LHU, 5'd8, 32'h0000_2002, 1'b0, 32'h104, 32'hBEEF_0000);
        #1;
        check("lhu_data", 64'(rd_data), 64'h0000_BEEF);
        tick(); exp_ins++;
        check_bypass("lhu", 1'b1, 5'd8, 32'h0000_BEEF);
        drive(1'b1, 1'b1, RF_LOAD, LD_LH, 5'd8, 32'h0000_2002, 1'b0, 32'h108, 32'hBEEF_0000);
        #1;
        check("lh_data", 64'(rd_data), 64'hFFFF_BEEF);
        tick(); exp_ins++;
        check_ctrs("lh");
        check_bypass("lh", 1'b1, 5'd8, 32'hFFFF_BEEF);

        // Mux paths with valid=0: data visible, no write, no retire
        drive(1'b0, 1'b1, RF_PC_PLUS4, LD_LW, 5'd4, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'h0);
        #1;
        check("pc4_wrap", 64'(rd_data), 64'h0);
        check("bubble_ldrf", 64'(load_regfile), 64'd0);
        drive(1'b0, 1'b1, RF_BR, LD_LW, 5'd4, 32'h0, 1'b1, 32'h0, 32'h0);
        #1;
        check("br_zext", 64'(rd_data), 64'h1);
        drive(1'b0, 1'b1, RF_LOAD, LD_LBU, 5'd4, 32'h0000_0001, 1'b0, 32'h0, 32'h0000_9A00);
        #1;
        check("lbu_data", 64'(rd_data), 64'h0000_009A);
        drive(1'b0, 1'b1, RF_LOAD, LD_LB, 5'd4, 32'h0000_0001, 1'b0, 32'h0, 32'h0000_9A00);
        #1;
        check("lb1_data", 64'(rd_data), 64'hFFFF_FF9A);
        check("bubble_mis", 64'(load_misalign), 64'd0);
        tick();
        check_ctrs("bubble");
        check_bypass("bubble", 1'b1, 5'd8, 32'hFFFF_BEEF);

        // ALU write held for three stalled cycles: retires once
        stall = 1'b1;
        drive(1'b1, 1'b1, RF_ALU, LD_LW, 5'd5, 32'h0000_1234, 1'b0, 32'h10C, 32'h0);
        #1;
        check("stall_ldrf0", 64'(load_regfile), 64'd1);
        tick(); exp_ins++;
        check_ctrs("stall1");
        check_bypass("stall1", 1'b1, 5'd5, 32'h0000_1234);
        check("stall_ldrf1", 64'(load_regfile), 64'd0);
        tick();
        check("stall_ldrf2", 64'(load_regfile), 64'd0);
        check_ctrs("stall2");
        tick();
        check_ctrs("stall3");
        stall = 1'b0;
        tick();
        check_ctrs("stall_rel");

        // Misaligned lw under stall: single pulse, one retire, no bypass update
        stall = 1'b1;
        drive(1'b1, 1'b1, RF_LOAD, LD_LW, 5'd9, 32'h0000_2002, 1'b0, 32'h110, 32'hDEAD_BEEF);
        #1;
        check("lw_mis_ldrf", 64'(load_regfile), 64'd0);
        check("lw_mis_pulse", 64'(load_misalign), 64'd1);
        tick(); exp_ins++;
        check("lw_mis_after", 64'(load_misalign), 64'd0);
        check_ctrs("lw_mis");
        check_bypass("lw_mis", 1'b1, 5'd5, 32'h0000_1234);
        tick();
        check("lw_mis_held", 64'(load_misalign), 64'd0);
        check_ctrs("lw_mis_held");
        stall = 1'b0;
        tick();

        // lh with odd offset, no stall
        drive(1'b1, 1'b1, RF_LOAD, LD_LH, 5'd10, 32'h0000_3001, 1'b0, 32'h114, 32'h1111_2222);
        #1;
        check("lh_mis_pulse", 64'(load_misalign), 64'd1);
        check("lh_mis_ldrf", 64'(load_regfile), 64'd0);
        tick(); exp_ins++;
        check_bypass("lh_mis", 1'b1, 5'd5, 32'h0000_1234);

        // Write to x0
        drive(1'b1, 1'b1, RF_ALU, LD_LW, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'h118, 32'h0);
        #1;
        check("x0_ldrf", 64'(load_regfile), 64'd0);
        tick(); exp_ins++;
        check_ctrs("x0");
        check_bypass("x0", 1'b1, 5'd5, 32'h0000_1234);

        // Reset asserted mid-stall, between clock edges
        stall = 1'b1;
        drive(1'b1, 1'b1, RF_ALU, LD_LW, 5'd3, 32'h0000_ABCD, 1'b0, 32'h11C, 32'h0);
        #1;
        check("rs_ldrf", 64'(load_regfile), 64'd1);
        tick(); exp_ins++;
        for (int i = 0; i < 9; i++) tick();
        check_ctrs("rs_pre");
        #2;
        reset = 1'b0;
        #1;
        exp_cyc = '0;
        exp_ins = '0;
        check_ctrs("rs_async");
        check_bypass("rs_async", 1'b0, 5'd0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("rs_post_ldrf", 64'(load_regfile), 64'd1);
        tick(); exp_ins++;
        check_ctrs("rs_post");
        check_bypass("rs_post", 1'b1, 5'd3, 32'h0000_ABCD);
        tick();
        check("rs_post_held", 64'(load_regfile), 64'd0);
        stall = 1'b0;
        drive(1'b0, 1'b0, RF_ALU, LD_LW, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        tick();

        // Counter wraparound
        for (int i = 0; i < 300; i++) tick();
        check_ctrs("wrap");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
